// File: rtl/mole_pkg.sv
// Shared definitions for the mole game: slot count, slot type, judge FSM
// states, score limit and the two-digit BCD score arithmetic.
package mole_pkg;

  localparam int unsigned NUM_SLOTS     = 3;
  localparam logic [7:0]  SCORE_MAX_BCD = 8'h99;

  typedef logic [1:0] slot_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ARMED  = 2'd2,
    LOCKED = 2'd3
  } judge_state_t;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == SCORE_MAX_BCD)  r = s;
    else if (s[3:0] == 4'd9) r = {s[7:4] + 4'd1, 4'd0};
    else                     r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  // Two-digit BCD decrement with tens borrow, floored at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h00)          r = s;
    else if (s[3:0] == 4'd0) r = {s[7:4] - 4'd1, 4'd9};
    else                     r = {s[7:4], s[3:0] - 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Conditions one raw active-low push-button: 2-flop synchronizer, stable-level
// debounce counter, and a one-cycle pulse on each released->pressed change.
// Ports:
//   clock, resetn  : clock and asynchronous active-low reset
//   key_n          : raw asynchronous key, 0 = pressed
//   press          : one-cycle pulse per accepted press
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronizer; idles at released.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Debounced level follows the synchronized level only after it has
  // differed for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Falling edge of the debounced level is a press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Player-side responder of the mole display protocol: judges conditioned key
// presses against the visible mole, pulses turnoff/hit on a correct hit or
// miss on a wrong one, and keeps a two-digit BCD score.
// Optional feature macro: HIT_JUDGE_MISS_PENALTY_EN -- each miss decrements
// the score (floor 00) and a single press with no mole up also counts as a miss.
// Ports:
//   clock, resetn         : clock and asynchronous active-low reset
//   game                  : run level; 0 idles the judge and clears the score
//   key_n[2:0]            : raw active-low keys, bit i = slot i
//   mole_valid, mole_slot : visible mole from the display controller
//   turnoff, hit, miss    : registered one-cycle pulses
//   score[7:0]            : BCD score, tens in [7:4], units in [3:0]
module hit_judge
  import mole_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       game,
  input  logic [2:0] key_n,
  input  logic       mole_valid,
  input  logic [1:0] mole_slot,
  output logic       turnoff,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score
);

  logic [NUM_SLOTS-1:0] press;
  logic [NUM_SLOTS-1:0] slot_mask;
  slot_t                slot;
  logic                 mole_up;

  judge_state_t state;
  judge_state_t state_nxt;
  logic         hit_nxt;
  logic         miss_nxt;
  logic [7:0]   score_nxt;

  // One conditioner per key.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clock (clock),
      .resetn(resetn),
      .key_n (key_n[i]),
      .press (press[i])
    );
  end

  // Slot 3 decodes to an empty mask, so it never matches and counts as no mole.
  assign slot      = slot_t'(mole_slot);
  assign slot_mask = NUM_SLOTS'(1) << slot;
  assign mole_up   = mole_valid && (slot != slot_t'(3));

  // Next state, pulses and score.
  always_comb begin
    state_nxt = state;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    score_nxt = score;
    case (state)
      IDLE: begin
        score_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
`ifdef HIT_JUDGE_MISS_PENALTY_EN
        if ($onehot(press)) begin
          miss_nxt  = 1'b1;
          score_nxt = bcd_dec(score);
        end
`endif
        if (mole_up) state_nxt = ARMED;
      end
      ARMED: begin
        // A vanishing mole wins over any same-cycle press.
        if (!mole_up) begin
          state_nxt = WAIT;
        end else if (press == slot_mask) begin
          hit_nxt   = 1'b1;
          score_nxt = bcd_inc(score);
          state_nxt = LOCKED;
        end else if (|press) begin
          miss_nxt = 1'b1;
`ifdef HIT_JUDGE_MISS_PENALTY_EN
          score_nxt = bcd_dec(score);
`endif
        end
      end
      LOCKED: begin
        if (!mole_up) state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
    if (!game) begin
      state_nxt = IDLE;
      hit_nxt   = 1'b0;
      miss_nxt  = 1'b0;
      score_nxt = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      turnoff <= 1'b0;
      hit     <= 1'b0;
      miss    <= 1'b0;
      score   <= '0;
    end else begin
      state   <= state_nxt;
      turnoff <= hit_nxt;
      hit     <= hit_nxt;
      miss    <= miss_nxt;
      score   <= score_nxt;
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge with DEBOUNCE_CYCLES=4: a cycle-level reference model
// checks every cycle, plus a vector table and directed corner sequences.
module tb_hit_judge;

  localparam int unsigned DC = 4;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       game = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       mole_valid = 1'b0;
  logic [1:0] mole_slot = 2'd0;
  logic       turnoff;
  logic       hit;
  logic       miss;
  logic [7:0] score;

  int n_checks = 0;
  int n_fail = 0;

  hit_judge #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .game      (game),
    .key_n     (key_n),
    .mole_valid(mole_valid),
    .mole_slot (mole_slot),
    .turnoff   (turnoff),
    .hit       (hit),
    .miss      (miss),
    .score     (score)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // m_hist[k] is key_n as sampled k rising edges ago.
  logic [2:0] m_hist [0:DC+1];
  logic [2:0] m_db = 3'b111;
  logic [2:0] m_went = 3'b000;
  logic [2:0] m_preg = 3'b000;
  bit         m_run = 0;
  bit         m_armed = 0;
  bit         m_locked = 0;
  int         m_score = 0;
  bit         e_hit = 0;
  bit         e_miss = 0;

  task automatic model_step;
    logic [2:0] pv;
    bit         stable;
    bit         mole_ok;
    if (!resetn) begin
      for (int k = 0; k <= DC + 1; k++) m_hist[k] = 3'b111;
      m_db = 3'b111; m_went = '0; m_preg = '0;
      m_run = 0; m_armed = 0; m_locked = 0; m_score = 0;
      e_hit = 0; e_miss = 0;
    end else begin
      for (int k = DC + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = key_n;
      pv = m_preg;
      m_preg = m_went;
      // A key level is accepted once DC consecutive synchronized samples differ.
      for (int i = 0; i < 3; i++) begin
        stable = 1;
        for (int k = 2; k <= DC + 1; k++)
          if (m_hist[k][i] == m_db[i]) stable = 0;
        m_went[i] = 1'b0;
        if (stable) begin
          m_db[i] = ~m_db[i];
          m_went[i] = ~m_db[i];
        end
      end
      e_hit = 0;
      e_miss = 0;
      mole_ok = mole_valid && (mole_slot != 2'd3);
      if (!game) begin
        m_run = 0; m_armed = 0; m_locked = 0; m_score = 0;
      end else if (!m_run) begin
        m_run = 1; m_score = 0;
      end else if (m_armed) begin
        if (!mole_ok) m_armed = 0;
        else if (pv != 3'b000) begin
          if ($countones(pv) == 1 && pv[mole_slot]) begin
            e_hit = 1;
            if (m_score < 99) m_score = m_score + 1;
            m_armed = 0;
            m_locked = 1;
          end else begin
            e_miss = 1;
`ifdef HIT_JUDGE_MISS_PENALTY_EN
            if (m_score > 0) m_score = m_score - 1;
`endif
          end
        end
      end else if (m_locked) begin
        if (!mole_ok) m_locked = 0;
      end else begin
`ifdef HIT_JUDGE_MISS_PENALTY_EN
        if ($countones(pv) == 1) begin
          e_miss = 1;
          if (m_score > 0) m_score = m_score - 1;
        end
`endif
        if (mole_ok) m_armed = 1;
      end
    end
  endtask

  task automatic model_check;
    logic [10:0] act;
    logic [10:0] exp;
    act = {turnoff, hit, miss, score};
    exp = {e_hit, e_hit, e_miss, 8'((m_score / 10) * 16 + (m_score % 10))};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t got {turnoff,hit,miss,score}=%h expected %h", $time, act, exp);
    end
  endtask

  always @(posedge clock) model_step();
  always @(negedge clock) model_check();

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic arm(input logic [1:0] slot);
    mole_valid = 1'b0;
    cyc(2);
    mole_slot = slot;
    mole_valid = 1'b1;
    cyc(2);
  endtask

  // Press mask held from the next edge; result must appear at edge DC+3.
  task automatic press_check(input string name, input logic [2:0] mask,
                             input logic eh, input logic em);
    key_n = ~mask;
    cyc(DC + 3);
    chk({name, "_early"}, 32'(hit | miss | turnoff), 32'd0);
    cyc(1);
    chk({name, "_hit"}, 32'(hit), 32'(eh));
    chk({name, "_turnoff"}, 32'(turnoff), 32'(eh));
    chk({name, "_miss"}, 32'(miss), 32'(em));
    key_n = 3'b111;
    cyc(10);
  endtask

  task automatic hit_fast(input logic [1:0] slot);
    arm(slot);
    key_n = ~(3'(3'b001 << slot));
    cyc(8);
    key_n = 3'b111;
    cyc(8);
  endtask

  task automatic game_restart;
    game = 1'b0;
    cyc(2);
    game = 1'b1;
    cyc(2);
  endtask

  typedef struct {
    logic [1:0] slot;
    logic [2:0] keys;
    logic       eh;
    logic       em;
    logic [7:0] score;
  } vec_t;

  vec_t tbl [6];
  bit   seen;

  initial begin
`ifdef HIT_JUDGE_MISS_PENALTY_EN
    tbl[0] = '{2'd1, 3'b010, 1'b1, 1'b0, 8'h01};
    tbl[1] = '{2'd2, 3'b001, 1'b0, 1'b1, 8'h00};
    tbl[2] = '{2'd2, 3'b110, 1'b0, 1'b1, 8'h00};
    tbl[3] = '{2'd0, 3'b001, 1'b1, 1'b0, 8'h01};
    tbl[4] = '{2'd2, 3'b100, 1'b1, 1'b0, 8'h02};
    tbl[5] = '{2'd1, 3'b011, 1'b0, 1'b1, 8'h01};
`else
    tbl[0] = '{2'd1, 3'b010, 1'b1, 1'b0, 8'h01};
    tbl[1] = '{2'd2, 3'b001, 1'b0, 1'b1, 8'h01};
    tbl[2] = '{2'd2, 3'b110, 1'b0, 1'b1, 8'h01};
    tbl[3] = '{2'd0, 3'b001, 1'b1, 1'b0, 8'h02};
    tbl[4] = '{2'd2, 3'b100, 1'b1, 1'b0, 8'h03};
    tbl[5] = '{2'd1, 3'b011, 1'b0, 1'b1, 8'h03};
`endif

    // Reset state.
    cyc(3);
    chk("rst_turnoff", 32'(turnoff), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_score", 32'(score), 32'h00);
    @(negedge clock); #2 resetn = 1'b1;
    cyc(2);

    // Vector table.
    game = 1'b1;
    cyc(2);
    for (int r = 0; r < 6; r++) begin
      arm(tbl[r].slot);
      press_check($sformatf("vec%0d", r), tbl[r].keys, tbl[r].eh, tbl[r].em);
      chk($sformatf("vec%0d_score", r), 32'(score), 32'(tbl[r].score));
    end

    // Second press on a struck mole is ignored.
    arm(2'd1);
    press_check("first_hit", 3'b010, 1'b1, 1'b0);
    press_check("locked_press", 3'b010, 1'b0, 1'b0);
`ifdef HIT_JUDGE_MISS_PENALTY_EN
    chk("locked_score", 32'(score), 32'h02);
`else
    chk("locked_score", 32'(score), 32'h04);
`endif

    // Short bounce yields no event.
    arm(2'd0);
    key_n = 3'b110;
    cyc(DC - 1);
    key_n = 3'b111;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      if (hit || miss) seen = 1;
    end
    chk("bounce_quiet", 32'(seen), 32'd0);

    // 09 -> 10 carry.
    game_restart();
    chk("restart_score", 32'(score), 32'h00);
    for (int n = 0; n < 9; n++) hit_fast(2'(n % 3));
    chk("score_09", 32'(score), 32'h09);
    arm(2'd0);
    press_check("carry_hit", 3'b001, 1'b1, 1'b0);
    chk("score_10", 32'(score), 32'h10);

    // Wrong slot keeps the mole armed; press with no mole up.
    arm(2'd2);
    press_check("wrong_slot", 3'b001, 1'b0, 1'b1);
`ifdef HIT_JUDGE_MISS_PENALTY_EN
    chk("borrow_score", 32'(score), 32'h09);
`else
    chk("wrong_score", 32'(score), 32'h10);
`endif
    press_check("still_armed", 3'b100, 1'b1, 1'b0);
    mole_valid = 1'b0;
    cyc(2);
`ifdef HIT_JUDGE_MISS_PENALTY_EN
    press_check("wait_press", 3'b001, 1'b0, 1'b1);
    chk("wait_score", 32'(score), 32'h09);
`else
    press_check("wait_press", 3'b001, 1'b0, 1'b0);
    chk("wait_score", 32'(score), 32'h11);
`endif

    // Mid-run reset clears outputs at once.
    @(negedge clock); #2 resetn = 1'b0;
    #1;
    chk("midrst_score", 32'(score), 32'h00);
    chk("midrst_pulses", 32'({turnoff, hit, miss}), 32'd0);
    cyc(2);
    @(negedge clock); #2 resetn = 1'b1;
    cyc(2);
    arm(2'd0);
    press_check("floor_miss", 3'b010, 1'b0, 1'b1);
    chk("floor_score", 32'(score), 32'h00);

    // Game off at 37 clears next edge; presses in IDLE ignored.
    for (int n = 0; n < 37; n++) hit_fast(2'(n % 3));
    chk("score_37", 32'(score), 32'h37);
    game = 1'b0;
    cyc(1);
    chk("game_off_score", 32'(score), 32'h00);
    arm(2'd0);
    press_check("idle_press", 3'b001, 1'b0, 1'b0);

    // Saturation at 99.
    game = 1'b1;
    cyc(2);
    for (int n = 0; n < 99; n++) hit_fast(2'(n % 3));
    chk("score_99", 32'(score), 32'h99);
    arm(2'd1);
    press_check("sat_hit", 3'b010, 1'b1, 1'b0);
    chk("sat_score", 32'(score), 32'h99);

    // Mole drops on the edge the press is judged.
    arm(2'd1);
    key_n = 3'b101;
    cyc(DC + 3);
    mole_valid = 1'b0;
    cyc(1);
    chk("race_pulses", 32'({hit, miss}), 32'd0);
    key_n = 3'b111;
    cyc(10);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 9) == 0) key_n[i] = ~key_n[i];
      if ($urandom_range(0, 7) == 0) mole_valid = ~mole_valid;
      if ($urandom_range(0, 15) == 0) mole_slot = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) game = ~game;
      if (!game && $urandom_range(0, 9) == 0) game = 1'b1;
      if ($urandom_range(0, 999) == 0) begin
        #2 resetn = 1'b0;
        cyc(2);
        #2 resetn = 1'b1;
      end
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
